// File: rtl/typed_arb_pkg.sv
// Shared types and wrap arithmetic for the typed round-robin arbiter.
// The burst-lock option (ARB_BURST_LOCK_EN) uses arb_state_t.
package typed_arb_pkg;

    typedef logic [32-1:0] arb_data_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index that follows ptr in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/typed_arb_rr_pick.sv
// Combinational round-robin pick: first set mask bit at or after the pointer,
// found by scanning the mask concatenated with itself.
module typed_arb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_mask,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int ID_W = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [ID_W:0]  pos;

    always_comb begin
        dbl   = {i_mask, i_mask};
        o_any = 1'b0;
        pos   = '0;
        // Descending scan so the lowest position inside the window wins.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i] && (i >= int'(i_ptr)) && (i < int'(i_ptr) + N)) begin
                o_any = 1'b1;
                pos   = (ID_W+1)'(i);
            end
        end
        if (pos >= (ID_W+1)'(N)) begin
            o_idx = ID_W'(pos - (ID_W+1)'(N));
        end else begin
            o_idx = pos[ID_W-1:0];
        end
        o_gnt = '0;
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/typed_rr_arbiter.sv
// N-way round-robin arbiter with a registered output beat and saturating beat counter.
// Define ARB_BURST_LOCK_EN to hold the grant on one requester until its last beat.
module typed_rr_arbiter
    import typed_arb_pkg::*;
#(
    parameter int  N     = 4,
    parameter type T     = arb_data_t,
    parameter int  CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req_valid,
    input  T                     i_req_data [N],
    input  logic [N-1:0]         i_req_last,
    output logic [N-1:0]         o_req_ready,
    output logic                 o_gnt_valid,
    output T                     o_gnt_data,
    output logic [$clog2(N)-1:0] o_gnt_id,
    input  logic                 i_gnt_ready,
    output logic [CNT_W-1:0]     o_gnt_count
);

    localparam int ID_W = $clog2(N);

    // Handshake: a beat moves on any side only in a cycle where valid and ready are both high.
    // Requesters hold valid/data until ready; the consumer sees a beat whenever o_gnt_valid is set.

    logic            gnt_valid_q, gnt_valid_d;
    T                gnt_data_q,  gnt_data_d;
    logic [ID_W-1:0] gnt_id_q,    gnt_id_d;
    logic [ID_W-1:0] ptr_q,       ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic            load;
    logic            accept;
    logic [N-1:0]    elig;
    logic [N-1:0]    pick_gnt;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;

`ifdef ARB_BURST_LOCK_EN
    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
`else
    logic            unused_last;
    assign unused_last = ^i_req_last;
`endif

    typed_arb_rr_pick #(.N(N)) u_pick (
        .i_mask (elig),
        .i_ptr  (ptr_q),
        .o_gnt  (pick_gnt),
        .o_idx  (pick_idx),
        .o_any  (pick_any)
    );

    always_comb begin
        load = !gnt_valid_q || i_gnt_ready;
        elig = i_req_valid;
`ifdef ARB_BURST_LOCK_EN
        // A locked burst excludes everyone else, even while the owner is idle.
        if (state_q == LOCKED) begin
            elig = i_req_valid & (N'(1) << owner_q);
        end
`endif
    end

    always_comb begin
        accept      = load && pick_any;
        o_req_ready = (accept && !i_rst) ? pick_gnt : '0;

        gnt_valid_d = gnt_valid_q;
        gnt_data_d  = gnt_data_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
`ifdef ARB_BURST_LOCK_EN
        state_d     = state_q;
        owner_d     = owner_q;
`endif

        if (load) begin
            gnt_valid_d = pick_any;
        end

        if (accept) begin
            gnt_data_d = i_req_data[pick_idx];
            gnt_id_d   = pick_idx;
`ifdef ARB_BURST_LOCK_EN
            if (i_req_last[pick_idx]) begin
                ptr_d   = ID_W'(rr_next(32'(pick_idx), N));
                state_d = IDLE;
            end else begin
                state_d = LOCKED;
                owner_d = pick_idx;
            end
`else
            ptr_d = ID_W'(rr_next(32'(pick_idx), N));
`endif
        end

        if (gnt_valid_q && i_gnt_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_valid_q <= 1'b0;
            gnt_data_q  <= '0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_data_q  <= gnt_data_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef ARB_BURST_LOCK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
`endif

    assign o_gnt_valid = gnt_valid_q;
    assign o_gnt_data  = gnt_data_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_gnt_count = cnt_q;

endmodule

// File: tb/tb_typed_rr_arbiter.sv
// Directed bench for typed_rr_arbiter: a cycle table plus hand sequences for burst lock,
// asynchronous reset mid-stall and counter saturation (second instance with CNT_W=4).
module tb_typed_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data [4];
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        gnt_valid;
    logic [31:0] gnt_data;
    logic [1:0]  gnt_id;
    logic        gnt_ready;
    logic [15:0] gnt_count;

    logic [3:0]  s_req_ready;
    logic        s_gnt_valid;
    logic [31:0] s_gnt_data;
    logic [1:0]  s_gnt_id;
    logic [3:0]  s_gnt_count;

    int n_checks = 0;
    int n_errors = 0;

    typed_rr_arbiter #(.N(4), .CNT_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_gnt_valid (gnt_valid),
        .o_gnt_data  (gnt_data),
        .o_gnt_id    (gnt_id),
        .i_gnt_ready (gnt_ready),
        .o_gnt_count (gnt_count)
    );

    typed_rr_arbiter #(.N(4), .CNT_W(4)) dut_sat (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (s_req_ready),
        .o_gnt_valid (s_gnt_valid),
        .o_gnt_data  (s_gnt_data),
        .o_gnt_id    (s_gnt_id),
        .i_gnt_ready (gnt_ready),
        .o_gnt_count (s_gnt_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       valid;
        logic [3:0][31:0] d;
        logic             rdy_in;
        logic [3:0]       exp_rdy;
        logic             exp_gv;
        logic             chk_dat;
        logic [1:0]       exp_id;
        logic [31:0]      exp_data;
        logic [15:0]      exp_cnt;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0][31:0] d,
                                input logic rdy_in, input logic [3:0] exp_rdy,
                                input logic exp_gv, input logic chk_dat,
                                input logic [1:0] exp_id, input logic [31:0] exp_data,
                                input logic [15:0] exp_cnt);
        vec_t v;
        v.valid = valid; v.d = d; v.rdy_in = rdy_in; v.exp_rdy = exp_rdy;
        v.exp_gv = exp_gv; v.chk_dat = chk_dat; v.exp_id = exp_id;
        v.exp_data = exp_data; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0][31:0] d, input logic rdy);
        req_valid = valid;
        for (int k = 0; k < 4; k++) req_data[k] = d[k];
        gnt_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0][31:0] df, dc, de, db;
    logic [1:0]       exp_ids [4];
    int               beats;
    logic             rdy1;

    initial begin
        df = {32'h0000_00F3, 32'h0000_00F2, 32'h0000_00F1, 32'h0000_00F0};
        dc = {32'h0000_00C3, 32'hA5A5_0001, 32'h0000_00C1, 32'h0000_00C0};
        de = {32'h0000_00E3, 32'h0000_00E2, 32'h0000_00E1, 32'h0000_00E0};

        // fairness: all valid, ids 0..3 twice
        for (int r = 0; r < 8; r++)
            vecs[r] = mk(4'b1111, df, 1'b1, 4'(1 << (r % 4)), 1'b1, 1'b1,
                         2'(r % 4), 32'h0000_00F0 + 32'(r % 4), 16'(r));
        vecs[8]  = mk(4'b0000, df, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0, 16'd8);
        // stall with req2 beat held, others waiting
        vecs[9]  = mk(4'b0100, dc, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 16'd8);
        vecs[10] = mk(4'b1011, dc, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 16'd8);
        vecs[11] = mk(4'b1011, dc, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 16'd8);
        vecs[12] = mk(4'b1011, dc, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 16'd8);
        vecs[13] = mk(4'b1011, dc, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 32'h0000_00C3, 16'd9);
        vecs[14] = mk(4'b0000, dc, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0, 16'd10);
        // wrap/skip: pointer moved to 3, then only req1, then req0+req3
        vecs[15] = mk(4'b0100, de, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 32'h0000_00E2, 16'd10);
        vecs[16] = mk(4'b0010, de, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 32'h0000_00E1, 16'd11);
        vecs[17] = mk(4'b1001, de, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 32'h0000_00E3, 16'd12);
        vecs[18] = mk(4'b0000, de, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0, 16'd13);
        // back-to-back from req0, fresh data each cycle
        for (int r = 19; r < 23; r++) begin
            db = de;
            db[0] = 32'h0B0B_0000 + 32'(r);
            vecs[r] = mk(4'b0001, db, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0,
                         32'h0B0B_0000 + 32'(r), 16'(r - 6));
        end
        vecs[23] = mk(4'b0000, de, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0, 16'd17);

        // reset state, with requests pending to show ready stays low in reset
        rst = 1'b1;
        req_last = 4'b1111;
        drive(4'b1111, df, 1'b0);
        #1;
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_gnt_data", gnt_data, 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_count", 32'(gnt_count), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b0;

        for (int r = 0; r < 24; r++) begin
            @(negedge clk);
            drive(vecs[r].valid, vecs[r].d, vecs[r].rdy_in);
            #1;
            chk($sformatf("v%0d_req_ready", r), 32'(req_ready), 32'(vecs[r].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_gnt_valid", r), 32'(gnt_valid), 32'(vecs[r].exp_gv));
            if (vecs[r].chk_dat) begin
                chk($sformatf("v%0d_gnt_id", r), 32'(gnt_id), 32'(vecs[r].exp_id));
                chk($sformatf("v%0d_gnt_data", r), gnt_data, vecs[r].exp_data);
            end
            chk($sformatf("v%0d_count", r), 32'(gnt_count), 32'(vecs[r].exp_cnt));
        end

        // burst from req1 (last on beat 3) while req0 stays valid; pointer primed to 1
`ifdef ARB_BURST_LOCK_EN
        exp_ids = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
        exp_ids = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
        do_reset();
        @(negedge clk);
        drive(4'b0001, df, 1'b1);
        @(negedge clk);
        req_valid = 4'b0000;
        beats = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = {2'b00, (beats < 3), 1'b1};
            req_last  = {2'b11, (beats == 2), 1'b1};
            req_data[1] = 32'h0000_1B00 + 32'(beats);
            #1;
            rdy1 = req_ready[1];
            @(posedge clk);
            #1;
            if (rdy1) beats++;
            chk($sformatf("burst%0d_gnt_valid", c), 32'(gnt_valid), 32'h1);
            chk($sformatf("burst%0d_gnt_id", c), 32'(gnt_id), 32'(exp_ids[c]));
        end
        req_last = 4'b1111;

        // asynchronous reset while a stalled beat is held
        @(negedge clk);
        drive(4'b0100, dc, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_pre_rst_valid", 32'(gnt_valid), 32'h1);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("stall_pre_rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("midrst_count", 32'(gnt_count), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        gnt_ready = 1'b1;
        #1;
        chk("post_rst_ptr0_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_gnt_id", 32'(gnt_id), 32'h0);

        // saturation: 20 accepted beats
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(4'b0001, df, 1'b1);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("sat_count_w16", 32'(gnt_count), 32'd20);
        chk("sat_count_w4", 32'(s_gnt_count), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
